fifo_burst_reader: RTL and testbench

- Read-side consumer of async_fifo, in the rd_clk domain.
- Watches rd_count/rd_empty and pops fixed-length bursts of BURST_LEN words once enough data is buffered.
- Absorbs the FIFO's 1-cycle read latency in a 2-entry output buffer and presents words on a valid/ready stream with a last flag.
- A timeout flushes a short tail burst so residual words below BURST_LEN never stall.

---
 rtl/fifo_burst_reader.sv | 131 +++++++++++++
 tb/tb_fifo_burst_reader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// Read-side burst consumer for async_fifo. Pops BURST_LEN-word bursts once
// enough data is buffered, hides the FIFO's 1-cycle read latency behind a
// 2-entry skid buffer, and flushes a short tail burst after an idle timeout.
module fifo_burst_reader #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 10,
  parameter int BURST_LEN   = 16,
  parameter int TIMEOUT     = 256
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   enable,
  output logic                   rd_en,
  input  logic [DATA_WIDTH-1:0]  rd_data,
  input  logic                   rd_empty,
  input  logic [COUNT_WIDTH-1:0] rd_count,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] burst_words
);

  // Timer needs at least one bit even when flushing is disabled.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [COUNT_WIDTH-1:0] BL     = COUNT_WIDTH'(BURST_LEN);
  localparam logic [COUNT_WIDTH-1:0] ONE    = COUNT_WIDTH'(1);
  localparam logic [TW-1:0]          T_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [TW-1:0]          T_MAX  = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_e;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  state_e                 state_q, state_d;
  logic [1:0]             occ_q, occ_d;
  logic                   inflight_q, inflight_d;
  logic                   infl_last_q, infl_last_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [COUNT_WIDTH-1:0] burst_words_q, burst_words_d;
  logic [TW-1:0]          timer_q, timer_d;
  entry_t [1:0]           mem_q, mem_d;
  logic                   wptr_q, wptr_d;
  logic                   rptr_q, rptr_d;
  logic                   pop;
  logic [2:0]             level_after_pop;

  assign m_valid     = (occ_q != 2'd0);
  assign m_data      = mem_q[rptr_q].data;
  assign m_last      = mem_q[rptr_q].last;
  assign busy        = (state_q != IDLE);
  assign burst_words = burst_words_q;
  assign pop         = m_valid && m_ready;

  // Buffered plus in-flight words left after this cycle's pop; a new read
  // is only allowed if its word is guaranteed a free entry on arrival.
  assign level_after_pop = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_en = (state_q == BURST) && !rd_empty && (remaining_q != '0) &&
                 (level_after_pop < 3'd2);

  // Next-state, burst length bookkeeping and idle timeout.
  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q - {{(COUNT_WIDTH-1){1'b0}}, rd_en};
    burst_words_d = burst_words_q;
    timer_d       = '0;
    unique case (state_q)
      IDLE: begin
        if (enable && rd_count >= BL) begin
          state_d       = BURST;
          remaining_d   = BL;
          burst_words_d = BL;
        end else if (enable && rd_count != '0) begin
          if (TIMEOUT != 0 && timer_q == T_LAST) begin
            state_d       = BURST;
            remaining_d   = rd_count;
            burst_words_d = rd_count;
          end else begin
            timer_d = (timer_q == T_MAX) ? timer_q : timer_q + 1'b1;
          end
        end
      end
      BURST: if (rd_en && remaining_q == ONE) state_d = DRAIN;
      DRAIN: if (occ_q == 2'd0 && !inflight_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Skid buffer: capture the word requested last cycle, retire on handshake.
  always_comb begin
    mem_d       = mem_q;
    wptr_d      = wptr_q ^ inflight_q;
    rptr_d      = rptr_q ^ pop;
    occ_d       = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    inflight_d  = rd_en;
    infl_last_d = rd_en && (remaining_q == ONE);
    if (inflight_q) mem_d[wptr_q] = '{last: infl_last_q, data: rd_data};
  end

  // State registers; reset discards any undelivered words.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      occ_q         <= '0;
      inflight_q    <= 1'b0;
      infl_last_q   <= 1'b0;
      remaining_q   <= '0;
      burst_words_q <= '0;
      timer_q       <= '0;
      mem_q         <= '0;
      wptr_q        <= 1'b0;
      rptr_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      occ_q         <= occ_d;
      inflight_q    <= inflight_d;
      infl_last_q   <= infl_last_d;
      remaining_q   <= remaining_d;
      burst_words_q <= burst_words_d;
      timer_q       <= timer_d;
      mem_q         <= mem_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a queue-based FIFO model feeds the DUT, a
// scoreboard checks every delivered beat against the words the FIFO handed
// out, and burst lengths are checked against the splitting rule.
module tb_fifo_burst_reader;
  localparam int DW = 8;
  localparam int CW = 10;
  localparam int BL = 16;
  localparam int TO = 256;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          enable = 1'b1;
  logic          rd_en;
  logic [DW-1:0] rd_data = '0;
  logic          rd_empty = 1'b1;
  logic [CW-1:0] rd_count = '0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          m_last;
  logic          busy;
  logic [CW-1:0] burst_words;

  fifo_burst_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .rd_en(rd_en), .rd_data(rd_data),
    .rd_empty(rd_empty), .rd_count(rd_count), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy), .burst_words(burst_words)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  logic [DW-1:0] fifo_q[$], pend_q[$], handed[$];
  int wr_gap = 0, wr_tick = 0, ready_mode = 0, rand_empty = 0;
  int stall_after = -1, stall_len = 3, stall_left = 0;
  int beats_n, rden_n, first_rden, last_rden, first_beat, last_beat;
  int busy_rise, busy_fall, first_count, max_out, cur_len, first_beat_data;
  int bursts[$];
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic prev_last;
  logic [DW-1:0] seq = '0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clr_logs();
    beats_n = 0; rden_n = 0; first_rden = -1; last_rden = -1;
    first_beat = -1; last_beat = -1; busy_rise = -1; busy_fall = -1;
    first_count = -1; max_out = 0; cur_len = 0; first_beat_data = -1;
    bursts.delete();
  endtask

  // FIFO model, stream sink and scoreboard.
  initial begin
    logic ren;
    logic [DW-1:0] expw;
    logic force_e;
    clr_logs();
    forever begin
      @(negedge clk);
      ren = rd_en;
      if (rstn) begin
        if (handed.size() > max_out) max_out = handed.size();
        if (rd_en) begin
          chk("rd_en_while_empty", int'(rd_empty), 0);
          if (rden_n == 0) first_rden = cyc;
          last_rden = cyc;
          rden_n++;
        end
        if (busy && busy_rise < 0) busy_rise = cyc;
        if (!busy && busy_rise >= 0 && busy_fall < 0) busy_fall = cyc;
        if (prev_stall) begin
          chk("hold_valid", int'(m_valid), 1);
          chk("hold_data", int'(m_data), int'(prev_data));
          chk("hold_last", int'(m_last), int'(prev_last));
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        if (m_valid && m_ready) begin
          if (beats_n == 0) begin first_beat = cyc; first_beat_data = int'(m_data); end
          last_beat = cyc;
          beats_n++;
          cur_len++;
          if (handed.size() == 0) chk("beat_without_read", 1, 0);
          else begin
            expw = handed.pop_front();
            chk("beat_data", int'(m_data), int'(expw));
          end
          if (m_last) begin
            chk("last_position", cur_len, int'(burst_words));
            bursts.push_back(cur_len);
            cur_len = 0;
          end
        end
      end else prev_stall = 1'b0;
      @(posedge clk);
      cyc++;
      #1;
      if (ren && rstn && fifo_q.size() > 0) begin
        rd_data = fifo_q.pop_front();
        handed.push_back(rd_data);
      end
      if (pend_q.size() > 0) begin
        if (wr_gap == 0) while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
        else begin
          if (wr_tick == 0) fifo_q.push_back(pend_q.pop_front());
          wr_tick = (wr_tick + 1) % wr_gap;
        end
      end
      if (first_count < 0 && fifo_q.size() > 0) first_count = cyc;
      if (stall_after >= 0 && rden_n == stall_after) begin
        stall_left = stall_len;
        stall_after = -1;
      end
      force_e = (stall_left > 0) || (rand_empty != 0 && $urandom_range(0, 7) == 0);
      if (stall_left > 0) stall_left--;
      rd_empty = (fifo_q.size() == 0) || force_e;
      rd_count = CW'(fifo_q.size());
      case (ready_mode)
        0: m_ready = 1'b1;
        1: m_ready = (cyc % 2 == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic load(input int n);
    for (int k = 0; k < n; k++) begin
      pend_q.push_back(seq);
      seq = seq + 8'd1;
    end
  endtask

  task automatic wait_done(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #2;
      if (beats_n >= n && !busy && fifo_q.size() == 0 && pend_q.size() == 0) break;
    end
  endtask

  // Expected split: full bursts while >= BL words, then one short tail.
  task automatic chk_split(input string nm, input int n);
    int exp_q[$];
    for (int k = 0; k < n / BL; k++) exp_q.push_back(BL);
    if (n % BL != 0) exp_q.push_back(n % BL);
    chk({nm, "_bursts"}, bursts.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < bursts.size(); k++)
      chk({nm, "_len"}, bursts[k], exp_q[k]);
  endtask

  typedef struct {
    string name;
    int n, gap, rmode, rnd_e, stall;
    int exp_bursts, exp_tail;
  } vec_t;

  vec_t vecs[6];
  int   exp_len;
  int   exp_front;

  initial begin
    vecs[0] = '{"full16",   16, 0, 0, 0, -1, 1, 16};
    vecs[1] = '{"toggle16", 16, 0, 1, 0, -1, 1, 16};
    vecs[2] = '{"tail5",     5, 0, 0, 0, -1, 1, 5};
    vecs[3] = '{"halfrate", 40, 2, 0, 0, -1, 3, 8};
    vecs[4] = '{"stall16",  16, 0, 0, 0,  5, 1, 16};
    vecs[5] = '{"rand33",   33, 1, 2, 1, -1, 3, 1};

    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_data", int'(m_data), 0);
    chk("rst_m_last", int'(m_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_burst_words", int'(burst_words), 0);
    @(negedge clk); #2 rstn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      #2;
      clr_logs();
      wr_gap = vecs[i].gap; wr_tick = 0; ready_mode = vecs[i].rmode;
      rand_empty = vecs[i].rnd_e; stall_after = vecs[i].stall;
      load(vecs[i].n);
      wait_done(vecs[i].n, 4000);
      chk({vecs[i].name, "_beats"}, beats_n, vecs[i].n);
      chk({vecs[i].name, "_nbursts"}, bursts.size(), vecs[i].exp_bursts);
      for (int k = 0; k + 1 < bursts.size(); k++) chk({vecs[i].name, "_full"}, bursts[k], BL);
      if (bursts.size() > 0) chk({vecs[i].name, "_tail"}, bursts[bursts.size()-1], vecs[i].exp_tail);
      chk({vecs[i].name, "_outstanding_le2"}, int'(max_out <= 2), 1);
      case (i)
        0: begin
          chk("full16_rden_n", rden_n, 16);
          chk("full16_rden_span", last_rden - first_rden, 15);
          chk("full16_beat_span", last_beat - first_beat, 15);
          chk("full16_first_valid", first_beat - busy_rise, 2);
          chk("full16_busy_fall", busy_fall - last_beat, 2);
        end
        2: begin
          chk("tail5_timeout_gap", int'(first_rden - first_count >= TO - 1 && first_rden - first_count <= TO + 1), 1);
          chk("tail5_burst_words", int'(burst_words), 5);
        end
        4: begin
          chk("stall_rden_n", rden_n, 16);
          chk("stall_rden_span", last_rden - first_rden, 18);
        end
        default: ;
      endcase
      rand_empty = 0; ready_mode = 0;
      repeat (3) @(negedge clk);
    end

    // enable dropped mid-burst: burst completes, tail held until re-enabled
    #2;
    clr_logs(); wr_gap = 0;
    load(20);
    for (int i = 0; i < 200 && rden_n < 1; i++) begin @(negedge clk); #2; end
    enable = 1'b0;
    repeat (400) @(negedge clk);
    #2;
    chk("en_off_bursts", bursts.size(), 1);
    chk("en_off_rden_n", rden_n, 16);
    chk("en_off_busy", int'(busy), 0);
    enable = 1'b1;
    wait_done(20, 2000);
    chk_split("en_on", 20);

    // reset during beat 7 of a burst
    repeat (3) @(negedge clk);
    #2;
    clr_logs();
    load(24);
    for (int i = 0; i < 400 && beats_n < 6; i++) begin @(negedge clk); #2; end
    chk("rstmid_beats_before", beats_n, 6);
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    chk("rstmid_m_valid", int'(m_valid), 0);
    chk("rstmid_m_data", int'(m_data), 0);
    chk("rstmid_m_last", int'(m_last), 0);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_rd_en", int'(rd_en), 0);
    chk("rstmid_burst_words", int'(burst_words), 0);
    handed.delete();
    repeat (3) @(negedge clk);
    #2;
    exp_len = fifo_q.size();
    exp_front = (exp_len > 0) ? int'(fifo_q[0]) : -1;
    clr_logs();
    rstn = 1'b1;
    wait_done(exp_len, 2000);
    chk("rstmid_beats_after", beats_n, exp_len);
    chk("rstmid_first_word", first_beat_data, exp_front);
    chk_split("rstmid", exp_len);

    // randomized traffic against the splitting rule
    for (int r = 0; r < 4; r++) begin
      int n;
      repeat (3) @(negedge clk);
      #2;
      n = int'($urandom_range(1, 50));
      clr_logs();
      wr_gap = int'($urandom_range(0, 2)); wr_tick = 0;
      ready_mode = 2; rand_empty = 1;
      load(n);
      wait_done(n, 5000);
      chk("rand_beats", beats_n, n);
      chk_split("rand", n);
      chk("rand_outstanding_le2", int'(max_out <= 2), 1);
      rand_empty = 0; ready_mode = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

endmodule
